// File: rtl/r4_bfly_out_serializer.sv
// r4_bfly_out_serializer
// Captures a radix-4 butterfly output group (four complex IEEE-754 singles)
// in one cycle and streams it out one complex sample per cycle, index
// order 0..3, over valid/ready. Buffers up to DEPTH groups.
// Optional: define R4_SER_SCALE_EN to scale each output word by 1/4 through
// an exponent adjustment on the output path (requires DATA_W == 32).
module r4_bfly_out_serializer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] Y0r,
    input  logic [DATA_W-1:0] Y1r,
    input  logic [DATA_W-1:0] Y2r,
    input  logic [DATA_W-1:0] Y3r,
    input  logic [DATA_W-1:0] Y0i,
    input  logic [DATA_W-1:0] Y1i,
    input  logic [DATA_W-1:0] Y2i,
    input  logic [DATA_W-1:0] Y3i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic [1:0]        out_idx,
    output logic              out_last,
    output logic              err_drop
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DATA_W-1:0] r_mem_re [DEPTH][4];
    logic [DATA_W-1:0] r_mem_im [DEPTH][4];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [1:0]        r_idx;
    logic              r_err_drop;

    logic              w_push;
    logic              w_pop;
    logic              w_free;
    logic [DATA_W-1:0] w_raw_re;
    logic [DATA_W-1:0] w_raw_im;

`ifdef R4_SER_SCALE_EN
    // Multiply a single-precision word by 1/4; tiny normals flush to signed zero.
    function automatic logic [DATA_W-1:0] f_scale(input logic [DATA_W-1:0] x);
        logic [7:0] e;
        e = x[30:23];
        if (e == 8'd255)
            f_scale = x;
        else if (e <= 8'd2)
            f_scale = {x[31], 31'b0};
        else
            f_scale = {x[31], e - 8'd2, x[22:0]};
    endfunction
`endif

    assign in_ready  = (r_count != FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_free    = w_pop && (r_idx == 2'd3);

    assign w_raw_re  = r_mem_re[r_rd_ptr][r_idx];
    assign w_raw_im  = r_mem_im[r_rd_ptr][r_idx];

    // Output path: combinational read of the current slot, forced to 0 when empty.
    always_comb begin
`ifdef R4_SER_SCALE_EN
        out_re = out_valid ? f_scale(w_raw_re) : '0;
        out_im = out_valid ? f_scale(w_raw_im) : '0;
`else
        out_re = out_valid ? w_raw_re : '0;
        out_im = out_valid ? w_raw_im : '0;
`endif
    end

    assign out_idx  = r_idx;
    assign out_last = out_valid && (r_idx == 2'd3);
    assign err_drop = r_err_drop;

    // Group storage: written whole on an accepted push; never reset (data only).
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_re[r_wr_ptr][0] <= Y0r;
            r_mem_re[r_wr_ptr][1] <= Y1r;
            r_mem_re[r_wr_ptr][2] <= Y2r;
            r_mem_re[r_wr_ptr][3] <= Y3r;
            r_mem_im[r_wr_ptr][0] <= Y0i;
            r_mem_im[r_wr_ptr][1] <= Y1i;
            r_mem_im[r_wr_ptr][2] <= Y2i;
            r_mem_im[r_wr_ptr][3] <= Y3i;
        end
    end

    // Control: pointers, group count, sample index and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_idx      <= 2'd0;
            r_err_drop <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_idx <= r_idx + 2'd1;
            if (w_free)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_free)
                r_count <= r_count + CW'(1);
            else if (!w_push && w_free)
                r_count <= r_count - CW'(1);
            if (in_valid && !in_ready)
                r_err_drop <= 1'b1;
        end
    end

endmodule

// File: doc/r4_bfly_out_serializer.md
Name: r4_bfly_out_serializer

Overview:
- Receiver for the radix-4 butterfly output bus: captures one group of four complex results (Y0..Y3, real and imaginary, IEEE-754 single) in a single cycle.
- Streams the group out one complex sample per cycle over a valid/ready interface, in index order 0,1,2,3.
- Buffers up to DEPTH groups so a butterfly issuing every 4 cycles can run without stalling while the downstream sink drains at 1 sample/cycle.

Parameters:
- DATA_W, 32, width of each real/imag word; must be 32 when R4_SER_SCALE_EN is defined.
- DEPTH, 2, number of 4-sample groups buffered; power of two, >=2.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  group present on Y* inputs.
- in_ready  out  1  buffer can accept a group; equals (count != DEPTH).
- Y0r,Y1r,Y2r,Y3r  in  DATA_W each  real parts of butterfly outputs 0..3.
- Y0i,Y1i,Y2i,Y3i  in  DATA_W each  imaginary parts of butterfly outputs 0..3.
- out_valid  out  1  sample available; equals (count != 0).
- out_ready  in  1  sink accepts the sample.
- out_re  out  DATA_W  real part of the current sample.
- out_im  out  DATA_W  imaginary part of the current sample.
- out_idx  out  2  butterfly output index of the current sample.
- out_last  out  1  high when out_idx==3 (last sample of a group).
- err_drop  out  1  sticky; set when in_valid && !in_ready.

Behaviour:
- State: group storage [DEPTH][4] complex, wr_ptr, rd_ptr (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH), idx (2 bits), err_drop.
- Reset (reset==0, asynchronous): pointers, count, idx and err_drop are cleared to 0. Outputs: out_valid=0, in_ready=1, out_idx=0, out_last=0, err_drop=0. out_re/out_im must be driven to 0 while count==0.
- Reset asserted mid-stream discards all buffered groups and any partially drained group; no sample may appear after reset is released until a new push.
- Push: when in_valid && in_ready, all 8 words are written to slot wr_ptr and wr_ptr increments.
- Pop: when out_valid && out_ready, the sample is transferred. If idx<3, idx increments. If idx==3, idx returns to 0 and rd_ptr increments (group freed).
- count update:
  - +1 on push only.
  - -1 on a group-freeing pop only.
  - Unchanged when both happen in the same cycle.
- Simultaneous events when full: in_ready depends only on count. A group-freeing pop in the same cycle does not allow a push that cycle; in_ready rises on the next cycle.
- Output path: out_re/out_im/out_idx are combinational from slot rd_ptr, index idx. No output register.
- Latency: a group pushed in cycle N presents sample 0 with out_valid=1 in cycle N+1 when the buffer was empty. Throughput is 1 sample/cycle with out_ready held high.
- Output data must remain stable while out_valid && !out_ready.
- Overflow: a push attempted while full is dropped, storage is not modified, and err_drop is set. err_drop clears only on reset.
- Data is passed bit-exact (no arithmetic) unless R4_SER_SCALE_EN is defined.

Optional Feature:
- Macro: R4_SER_SCALE_EN. When defined, out_re and out_im are each multiplied by 1/4 (inverse-transform normalisation) by adjusting the exponent, applied combinationally on the output path. Rules, by biased exponent e:
  - e==255 (Inf/NaN): passed unchanged.
  - e==0 (zero/denormal): output is the sign bit followed by zeros.
  - 1<=e<=2: flushed to sign-preserving zero.
  - e>=3: e is replaced by e-2 and the mantissa is unchanged.
- When not defined: output is bit-exact and no scaling logic is present.

Test Plan:
- Reset, then push one group with Y0r=0x3F800000, Y1r=0x40000000, Y2r=0x40400000, Y3r=0x40800000, all Yi=0, out_ready=1. Expect out_valid from the next cycle; 4 beats with out_re 0x3F800000, 0x40000000, 0x40400000, 0x40800000; out_idx 0..3; out_last only on beat 3. Then out_valid=0.
- Push 2 groups back-to-back with out_ready=0. Expect in_ready=0 after the 2nd push. A 3rd push sets err_drop=1. Drain with out_ready=1: exactly 8 beats, from the first two groups only.
- Hold out_ready=0 for 5 cycles mid-group at idx=2. out_re/out_im/out_idx stay constant; the sample is transferred on the first cycle out_ready=1.
- Full buffer, out_ready=1, and in_valid=1 during the beat with out_last=1. The push is not accepted that cycle (in_ready=0, err_drop=1). in_ready=1 the next cycle and the push is accepted then.
- Assert reset for 1 cycle after beat 1 of a group with a second group queued. After release: out_valid=0, in_ready=1, err_drop=0, and no stale beats appear.
- With R4_SER_SCALE_EN defined: Y0r=0x3F800000 -> 0x3E800000; Y1r=0xC0000000 -> 0xBF000000; Y2r=0x00800000 -> 0x00000000; Y3r=0x7F800000 -> 0x7F800000.
